// File: rtl/ro_ctrl_pkg.sv
// Shared definitions for the ring-oscillator measurement controller:
// state encoding, stop-phase length and timer sizing helper.
package ro_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_STOP    = 3'd3,
    ST_DONE    = 3'd4
  } ro_state_t;

  // Cycles spent with the oscillator off so the synchronizer drains.
  localparam int unsigned RO_STOP_CYCLES = 2;

  // Timer holds 0 .. max(a, b, RO_STOP_CYCLES)-1.
  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m < RO_STOP_CYCLES) m = RO_STOP_CYCLES;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Three-flop synchronizer with rising-edge detect for an asynchronous input.
// edge_pulse is high for one clk cycle per rising edge seen on async_in.
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  // sync[0], sync[1] form the metastability chain; sync[2] delays for edge detect.
  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], async_in};
    end
  end

  assign edge_pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle,
// counts its rising edges over a fixed clk window, then reports the count.
module ro_freq_meter
  import ro_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_clk,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned TMR_W = tmr_width(SETTLE_CYCLES, GATE_CYCLES);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] STOP_LAST   = TMR_W'(RO_STOP_CYCLES - 1);

  ro_state_t        state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_flag;
  logic             edge_pulse;

  ro_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (ro_clk),
    .edge_pulse(edge_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
      ro_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          // DONE accepts start too, allowing back-to-back windows.
          if (start) begin
            state    <= ST_SETTLE;
            timer    <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            ro_en    <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            state <= ST_MEASURE;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_MEASURE: begin
          if (edge_pulse) begin
            if (edge_cnt == '1) ovf_flag <= 1'b1;
            else                edge_cnt <= edge_cnt + CNT_W'(1);
          end
          if (timer == GATE_LAST) begin
            state <= ST_STOP;
            timer <= '0;
            ro_en <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_STOP: begin
          if (timer == STOP_LAST) begin
            state    <= ST_DONE;
            timer    <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            count    <= edge_cnt;
            overflow <= ovf_flag;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
          ro_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: three instances (nominal, 4-bit saturating,
// short window) driven by a gated 25 MHz behavioral oscillator.
module tb_ro_freq_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic osc = 1'b0;
  logic osc_dead = 1'b0;

  logic [2:0]  start_v = 3'b000;
  logic [2:0]  ro_en_v, busy_v, done_v, ovf_v, ro_clk_v;
  logic [15:0] count_n;
  logic [3:0]  count_s, count_g;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  initial begin
    #3;
    forever #20 osc = ~osc;
  end

  assign ro_clk_v = {3{osc & ~osc_dead}} & ro_en_v;

  ro_freq_meter #(.SETTLE_CYCLES(16), .GATE_CYCLES(1000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .ro_clk(ro_clk_v[0]),
    .ro_en(ro_en_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .count(count_n), .overflow(ovf_v[0]));

  ro_freq_meter #(.SETTLE_CYCLES(16), .GATE_CYCLES(200), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start_v[1]), .ro_clk(ro_clk_v[1]),
    .ro_en(ro_en_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .count(count_s), .overflow(ovf_v[1]));

  ro_freq_meter #(.SETTLE_CYCLES(16), .GATE_CYCLES(40), .CNT_W(4)) dut_g40 (
    .clk(clk), .rst(rst), .start(start_v[2]), .ro_clk(ro_clk_v[2]),
    .ro_en(ro_en_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .count(count_g), .overflow(ovf_v[2]));

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return int'(count_n);
      1:       return int'(count_s);
      default: return int'(count_g);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Pulse start for one cycle; lat = cycles from sampling edge to done (-1 on timeout).
  task automatic measure(input int sel, input int budget, output int lat);
    lat = -1;
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1 start_v[sel] = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("busy_after_start", int'(busy_v[sel]), 1, 1);
        check("ro_en_after_start", int'(ro_en_v[sel]), 1, 1);
      end
      if (done_v[sel]) begin
        lat = n;
        check("busy_in_done", int'(busy_v[sel]), 0, 0);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check("done_one_cycle", int'(done_v[sel]), 0, 0);
  endtask

  typedef struct {
    int sel;
    bit dead;
    int lo;
    int hi;
    int ovf;
    int lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int dn[$];
    int low_run;
    bit seen_high;
    int ndone;

    vecs[0] = '{sel: 0, dead: 1'b0, lo: 249, hi: 251, ovf: 0, lat: 1018};
    vecs[1] = '{sel: 0, dead: 1'b1, lo: 0,   hi: 0,   ovf: 0, lat: 1018};
    vecs[2] = '{sel: 1, dead: 1'b0, lo: 15,  hi: 15,  ovf: 1, lat: 218};
    vecs[3] = '{sel: 1, dead: 1'b1, lo: 0,   hi: 0,   ovf: 0, lat: 218};
    vecs[4] = '{sel: 2, dead: 1'b0, lo: 9,   hi: 11,  ovf: 0, lat: 58};
    vecs[5] = '{sel: 0, dead: 1'b0, lo: 249, hi: 251, ovf: 0, lat: 1018};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ro_en", int'(ro_en_v), 0, 0);
    check("rst_busy", int'(busy_v), 0, 0);
    check("rst_done", int'(done_v), 0, 0);
    check("rst_ovf", int'(ovf_v), 0, 0);
    check("rst_count", int'(count_n), 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Table-driven measurements
    for (int i = 0; i < 6; i++) begin
      osc_dead = vecs[i].dead;
      measure(vecs[i].sel, 1200, lat);
      check("latency", lat, vecs[i].lat, vecs[i].lat);
      check("count", cnt_of(vecs[i].sel), vecs[i].lo, vecs[i].hi);
      check("overflow", int'(ovf_v[vecs[i].sel]), vecs[i].ovf, vecs[i].ovf);
      $display("[TB] vec %0d sel=%0d dead=%0d lat=%0d count=%0d ovf=%0d", i,
               vecs[i].sel, vecs[i].dead, lat, cnt_of(vecs[i].sel), ovf_v[vecs[i].sel]);
    end
    osc_dead = 1'b0;

    // Start while busy: second pulse mid-MEASURE must be ignored
    lat = -1;
    ndone = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      start_v[0] = (n == 500);
      if (done_v[0]) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
    start_v[0] = 1'b0;
    check("busy_start_latency", lat, 1018, 1018);
    check("busy_start_ndone", ndone, 1, 1);
    check("busy_start_count", int'(count_n), 249, 251);
    check("busy_start_idle", int'(busy_v[0]), 0, 0);
    $display("[TB] start-while-busy lat=%0d dones=%0d count=%0d", lat, ndone, count_n);

    // Asynchronous reset in MEASURE cycle 300
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (16 + 300) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ro_en", int'(ro_en_v[0]), 0, 0);
    check("arst_busy", int'(busy_v[0]), 0, 0);
    check("arst_count", int'(count_n), 0, 0);
    #1 rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 1100; n++) begin
      @(negedge clk);
      if (done_v[0] || ro_en_v[0]) ndone++;
    end
    check("arst_no_done", ndone, 0, 0);
    measure(0, 1200, lat);
    check("arst_rerun_latency", lat, 1018, 1018);
    check("arst_rerun_count", int'(count_n), 249, 251);
    $display("[TB] async-reset rerun lat=%0d count=%0d", lat, count_n);

    // Back-to-back: start held high across three windows
    low_run = 0;
    seen_high = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int n = 0; n < 3300 && dn.size() < 3; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        dn.push_back(n);
        check("b2b_count", int'(count_n), 249, 251);
        $display("[TB] b2b done at %0d count=%0d", n, count_n);
      end
      if (ro_en_v[0]) begin
        if (seen_high && low_run > 0) check("b2b_gap", low_run, 3, 3);
        seen_high = 1'b1;
        low_run = 0;
      end else if (seen_high) begin
        low_run++;
      end
    end
    start_v[0] = 1'b0;
    check("b2b_ndone", dn.size(), 3, 3);
    if (dn.size() == 3) begin
      check("b2b_period1", dn[1] - dn[0], 1019, 1019);
      check("b2b_period2", dn[2] - dn[1], 1019, 1019);
    end
    @(negedge clk);
    check("b2b_to_idle_busy", int'(busy_v[0]), 0, 0);
    check("b2b_to_idle_ro_en", int'(ro_en_v[0]), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
